// File: rtl/boron_sbox_sequencer.sv
// Nibble-serial substitution-layer controller for the Boron cipher datapath.
// A 64-bit state word is accepted over valid/ready, streamed LSB-first through
// LANES external 4-bit S-boxes (LANES nibbles per cycle), reassembled in place
// and returned over valid/ready. The S-boxes are combinational and live outside.
module boron_sbox_sequencer #(
  parameter int LANES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [63:0]          in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          out_data,
  output logic [4*LANES-1:0]   sbox_in,
  input  logic [4*LANES-1:0]   sbox_out,
  output logic                 busy
);

  localparam int STEPS = 16 / LANES;
  // One extra bit so the count can reach STEPS without wrapping inside a block.
  localparam int CNT_W = $clog2(STEPS) + 1;

  // Only lane counts that tile the 16 nibbles exactly are meaningful.
  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_lanes_check
    $error("boron_sbox_sequencer: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0][3:0] data_q, data_d;

  // Nibble index handled by lane j during step c: lanes cover consecutive
  // nibbles, steps walk upward from nibble 0 (LSB-first).
  function automatic logic [3:0] lane_idx(input logic [CNT_W-1:0] c, input int j);
    return 4'(int'(c) * LANES + j);
  endfunction

  // State, step counter and working word; reset and flush both abort the block.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end

  // Next-state logic, in-place nibble substitution and handshake outputs.
  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    busy      = 1'b0;
    sbox_in   = '0;
    case (st_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d = in_data;
          cnt_d  = '0;
          st_d   = SUB;
        end
      end
      SUB: begin
        busy = 1'b1;
        for (int j = 0; j < LANES; j++) begin
          sbox_in[4*j +: 4]          = data_q[lane_idx(cnt_q, j)];
          data_d[lane_idx(cnt_q, j)] = sbox_out[4*j +: 4];
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          st_d = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = data_q;
        if (out_ready) begin
          st_d = IDLE;
        end
      end
      default: begin
        st_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/boron_sbox_sequencer.md
Name: boron_sbox_sequencer

Overview:
- Nibble-serial substitution-layer controller for the Boron cipher datapath.
- Accepts a 64-bit state word over a valid/ready handshake and time-multiplexes it through LANES shared 4-bit S-box instances, LANES nibbles per cycle.
- Reassembles the substituted word and returns it on a valid/ready output.
- The S-box instances sit outside the block and connect through sbox_in/sbox_out. This lets the round controller trade area for latency without changing the substitution table.

Parameters:
- LANES, 1, number of S-box instances driven in parallel. Legal values are 1, 2, 4, 8, 16 (must divide 16); any other value fails elaboration.
- STEPS, 16/LANES, derived (localparam), cycles spent in SUB per block.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous abort; returns the block to IDLE and discards in-flight data
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word
- in_data  in  64  state word to substitute
- out_valid  out  1  substituted word available
- out_ready  in  1  downstream accepts the word
- out_data  out  64  substituted word
- sbox_in  out  4*LANES  nibbles presented to the S-boxes; lane j occupies bits [4j+3:4j]
- sbox_out  in  4*LANES  S-box results; combinational, same-cycle
- busy  out  1  high in SUB or DONE

Behaviour:
- Reset: rst sampled high at a clock edge sets the state to IDLE, cnt=0, and the state register to 0. After reset: in_ready=1, out_valid=0, out_data=0, busy=0, sbox_in=0.
- rst has priority over flush; flush has priority over all handshakes.
- Flush takes effect at the edge where it is sampled high, with the same effect as reset on state, cnt and outputs. The state register may be left unchanged or cleared; out_data is don't-care while out_valid=0.
- FSM states: IDLE, SUB, DONE.
  - IDLE: in_ready=1. On in_valid=1, capture in_data into the 64-bit state register, set cnt=0, go to SUB. Otherwise stay in IDLE.
  - SUB: in_ready=0, busy=1.
    - Lane j is driven with nibble index n = cnt*LANES + j, where nibble n is state[4n+3:4n]. Nibble 0 is the LSBs, so processing runs LSB-first.
    - At each edge, the state nibbles at those indices are replaced with the corresponding sbox_out lanes and cnt increments.
    - When cnt == STEPS-1 at an edge, go to DONE. cnt is $clog2(STEPS)+1 bits wide and never wraps within a block.
  - DONE: out_valid=1, out_data=state register, in_ready=0, sbox_in=0. On out_ready=1, go to IDLE. While out_ready=0, hold out_valid and out_data stable indefinitely.
- sbox_in is 0 in every state other than SUB.
- Latency:
  - If the input handshake completes at edge E, out_valid is first high in the cycle after edge E+STEPS.
  - LANES=1: 16 cycles. LANES=16: 1 cycle.
  - Minimum initiation interval is STEPS+2 cycles (IDLE accept, STEPS SUB cycles, DONE with out_ready=1).
- in_valid and in_data are ignored while not in IDLE. The source must hold them, per the handshake, until in_ready is high.
- out_ready is ignored outside DONE.
- There is no same-cycle pass-through: a word accepted in IDLE never appears at out_data in the same cycle.
- Mid-operation reset or flush: partially substituted data is dropped and is never presented with out_valid=1.

Test Plan:
- Attach a behavioural S-box model (0→E, 1→4, 2→B, 3→1, 4→7, 5→9, 6→C, 7→A, 8→D, 9→2, A→0, B→F, C→8, D→5, E→3, F→6) to sbox_in/sbox_out for every scenario below.
- LANES=1, in_data=0x0123456789ABCDEF, out_ready=1 → out_data=0xE4B179CAD20F8536. out_valid first high exactly 16 cycles after the accept edge, for one cycle. busy high for 17 cycles.
- LANES=4, in_data=0x0000000000000000 then 0xFFFFFFFFFFFFFFFF back-to-back → out_data=0xEEEEEEEEEEEEEEEE then 0x6666666666666666. Each result appears 4 cycles after its accept. in_ready is low from accept until the output handshake completes.
- LANES=1, nibble-order check: in_data=0x00000000000000A0; monitor sbox_in → cycle 0 presents 0x0, cycle 1 presents 0xA. Final out_data=0xEEEEEEEEEEEEEE0E.
- Output stall, LANES=2: hold out_ready=0 for 10 cycles after out_valid rises → out_valid and out_data stay stable and in_ready stays 0, with a new in_valid ignored. When out_ready=1, return to IDLE the next cycle with in_ready=1.
- Flush and reset, LANES=1:
  - Assert flush at SUB cycle 7 → next cycle IDLE, in_ready=1, busy=0, no out_valid pulse. A following word 0x0123456789ABCDEF still yields 0xE4B179CAD20F8536.
  - Repeat with rst in place of flush → same outcome, with out_data=0.
  - rst and flush asserted together → reset values.
